// File: rtl/ram_dma_controller.sv
// DMA sequencer moving word blocks between port B of the CI dual-port SSRAM and
// the system bus in bursts. The CPU configures it through custom-instruction accesses.
module ram_dma_controller #(
    parameter int nrOfEntries = 512,
    localparam int AW = $clog2(nrOfEntries)
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          ciStart,
    input  logic [31:0]   ciValueA,
    input  logic [31:0]   ciValueB,
    output logic          ciDone,
    output logic [31:0]   ciResult,
    output logic [AW-1:0] ramAddressB,
    output logic          ramWriteEnableB,
    output logic [31:0]   ramDataInB,
    input  logic [31:0]   ramDataOutB,
    output logic          busRequest,
    output logic          beginTransaction,
    output logic          readNotWrite,
    output logic          endTransactionOut,
    output logic          dataValidOut,
    output logic [31:0]   addressDataOut,
    output logic [7:0]    burstSize,
    input  logic          busGrant,
    input  logic          endTransactionIn,
    input  logic          dataValidIn,
    input  logic          busyIn,
    input  logic          busError,
    input  logic [31:0]   addressDataIn
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_INIT, S_READ, S_WRITE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   bus_start_q, bus_start_d;
    logic [AW-1:0] mem_start_q, mem_start_d;
    logic [9:0]    block_size_q, block_size_d;
    logic [7:0]    burst_len_q, burst_len_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
    logic          dir_q, dir_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [9:0]    remaining_q, remaining_d;
    logic [8:0]    burst_words_q, burst_words_d;
    logic [8:0]    word_cnt_q, word_cnt_d;
    logic          ci_done_q, ci_done_d;
    logic [31:0]   ci_result_q, ci_result_d;
    logic          bus_req_q, bus_req_d;
    logic          begin_q, begin_d;
    logic          rnw_q, rnw_d;
    logic          end_out_q, end_out_d;
    logic          dv_q, dv_d;
    logic [31:0]   addr_data_q, addr_data_d;
    logic [7:0]    burst_size_q, burst_size_d;

    logic [2:0]    sel;
    logic          ci_wr;
    logic          start_req;
    logic [31:0]   rd_data;
    logic [9:0]    burst_max;
    logic          unused_ci;

    assign sel       = ciValueA[12:10];
    assign ci_wr     = ciStart && ciValueA[9];
    assign start_req = ci_wr && (sel == 3'd5) && (ciValueB[0] || ciValueB[1]) && !busy_q;
    assign burst_max = {2'b00, burst_len_q} + 10'd1;
    assign unused_ci = ^{ciValueA[31:13], ciValueA[8:0]};

    always_comb begin
        rd_data = '0;
        case (sel)
            3'd1:    rd_data = bus_start_q;
            3'd2:    rd_data = {{(32-AW){1'b0}}, mem_start_q};
            3'd3:    rd_data = {22'd0, block_size_q};
            3'd4:    rd_data = {24'd0, burst_len_q};
            3'd5:    rd_data = {30'd0, error_q, busy_q};
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        bus_start_d     = bus_start_q;
        mem_start_d     = mem_start_q;
        block_size_d    = block_size_q;
        burst_len_d     = burst_len_q;
        busy_d          = busy_q;
        error_d         = error_q;
        dir_d           = dir_q;
        bus_addr_d      = bus_addr_q;
        mem_addr_d      = mem_addr_q;
        remaining_d     = remaining_q;
        burst_words_d   = burst_words_q;
        word_cnt_d      = word_cnt_q;
        ramAddressB     = '0;
        ramWriteEnableB = 1'b0;
        ramDataInB      = '0;

        if (ci_wr) begin
            case (sel)
                3'd1:    bus_start_d  = {ciValueB[31:2], 2'b00};
                3'd2:    mem_start_d  = ciValueB[AW-1:0];
                3'd3:    block_size_d = ciValueB[9:0];
                3'd4:    burst_len_d  = ciValueB[7:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    error_d = 1'b0;
                    if (block_size_q != '0) begin
                        busy_d      = 1'b1;
                        dir_d       = ciValueB[0];
                        bus_addr_d  = bus_start_q;
                        mem_addr_d  = mem_start_q;
                        remaining_d = block_size_q;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (busGrant) begin
                    burst_words_d = (burst_max < remaining_q) ? burst_max[8:0] : remaining_q[8:0];
                    word_cnt_d    = '0;
                    state_d       = S_INIT;
                end
            end
            S_INIT: begin
                if (!dir_q) ramAddressB = mem_addr_q;
                state_d = dir_q ? S_READ : S_WRITE;
            end
            S_READ: begin
                ramAddressB = mem_addr_q;
                if (dataValidIn && (word_cnt_q != burst_words_q)) begin
                    ramWriteEnableB = 1'b1;
                    ramDataInB      = addressDataIn;
                    mem_addr_d      = mem_addr_q + AW'(1);
                    remaining_d     = remaining_q - 10'd1;
                    word_cnt_d      = word_cnt_q + 9'd1;
                end
                if (endTransactionIn) state_d = S_DONE;
            end
            S_WRITE: begin
                // Port B is one word ahead of the bus so the registered data output
                // can take the next word directly when the current one is accepted.
                ramAddressB = mem_addr_q + AW'(1);
                if (!busyIn) begin
                    mem_addr_d  = mem_addr_q + AW'(1);
                    remaining_d = remaining_q - 10'd1;
                    word_cnt_d  = word_cnt_q + 9'd1;
                    if (word_cnt_q + 9'd1 == burst_words_q) state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus_addr_d = bus_addr_q + {21'd0, word_cnt_q, 2'b00};
                if (remaining_q != '0) begin
                    state_d = S_REQ;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (busError && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_comb begin
        bus_req_d    = state_d inside {S_REQ, S_INIT, S_READ, S_WRITE};
        begin_d      = (state_d == S_INIT);
        end_out_d    = (state_q == S_WRITE) && (state_d == S_DONE);
        rnw_d        = 1'b0;
        dv_d         = 1'b0;
        addr_data_d  = '0;
        burst_size_d = '0;
        ci_done_d    = ciStart;
        ci_result_d  = ciStart ? rd_data : '0;
        if (state_d == S_INIT) begin
            addr_data_d  = bus_addr_q;
            burst_size_d = burst_words_d[7:0] - 8'd1;
            rnw_d        = dir_q;
        end else if (state_d == S_WRITE) begin
            dv_d        = 1'b1;
            addr_data_d = ((state_q == S_WRITE) && busyIn) ? addr_data_q : ramDataOutB;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q       <= S_IDLE;
            bus_start_q   <= '0;
            mem_start_q   <= '0;
            block_size_q  <= '0;
            burst_len_q   <= '0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            dir_q         <= 1'b0;
            bus_addr_q    <= '0;
            mem_addr_q    <= '0;
            remaining_q   <= '0;
            burst_words_q <= '0;
            word_cnt_q    <= '0;
            ci_done_q     <= 1'b0;
            ci_result_q   <= '0;
            bus_req_q     <= 1'b0;
            begin_q       <= 1'b0;
            rnw_q         <= 1'b0;
            end_out_q     <= 1'b0;
            dv_q          <= 1'b0;
            addr_data_q   <= '0;
            burst_size_q  <= '0;
        end else begin
            state_q       <= state_d;
            bus_start_q   <= bus_start_d;
            mem_start_q   <= mem_start_d;
            block_size_q  <= block_size_d;
            burst_len_q   <= burst_len_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            dir_q         <= dir_d;
            bus_addr_q    <= bus_addr_d;
            mem_addr_q    <= mem_addr_d;
            remaining_q   <= remaining_d;
            burst_words_q <= burst_words_d;
            word_cnt_q    <= word_cnt_d;
            ci_done_q     <= ci_done_d;
            ci_result_q   <= ci_result_d;
            bus_req_q     <= bus_req_d;
            begin_q       <= begin_d;
            rnw_q         <= rnw_d;
            end_out_q     <= end_out_d;
            dv_q          <= dv_d;
            addr_data_q   <= addr_data_d;
            burst_size_q  <= burst_size_d;
        end
    end

    assign ciDone            = ci_done_q;
    assign ciResult          = ci_result_q;
    assign busRequest        = bus_req_q;
    assign beginTransaction  = begin_q;
    assign readNotWrite      = rnw_q;
    assign endTransactionOut = end_out_q;
    assign dataValidOut      = dv_q;
    assign addressDataOut    = addr_data_q;
    assign burstSize         = burst_size_q;

endmodule

// File: tb/tb_ram_dma_controller.sv
// Directed bench for ram_dma_controller: CI register access, both transfer
// directions, stalls, address wrap, bus error with retry, ignored start and reset.
module tb_ram_dma_controller;

    localparam int N = 512;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        ciStart = 1'b0;
    logic [31:0] ciValueA = '0;
    logic [31:0] ciValueB = '0;
    logic        ciDone;
    logic [31:0] ciResult;
    logic [8:0]  ramAddressB;
    logic        ramWriteEnableB;
    logic [31:0] ramDataInB;
    logic [31:0] ramDataOutB;
    logic        busRequest, beginTransaction, readNotWrite, endTransactionOut, dataValidOut;
    logic [31:0] addressDataOut;
    logic [7:0]  burstSize;
    logic        busGrant = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        dataValidIn = 1'b0;
    logic        busyIn = 1'b0;
    logic        busError = 1'b0;
    logic [31:0] addressDataIn = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:N-1] = '{default: '0};

    ram_dma_controller #(.nrOfEntries(N)) dut (
        .clock(clock), .resetN(resetN),
        .ciStart(ciStart), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone), .ciResult(ciResult),
        .ramAddressB(ramAddressB), .ramWriteEnableB(ramWriteEnableB),
        .ramDataInB(ramDataInB), .ramDataOutB(ramDataOutB),
        .busRequest(busRequest), .beginTransaction(beginTransaction),
        .readNotWrite(readNotWrite), .endTransactionOut(endTransactionOut),
        .dataValidOut(dataValidOut), .addressDataOut(addressDataOut),
        .burstSize(burstSize), .busGrant(busGrant),
        .endTransactionIn(endTransactionIn), .dataValidIn(dataValidIn),
        .busyIn(busyIn), .busError(busError), .addressDataIn(addressDataIn)
    );

    always #5 clock = ~clock;

    // Port-B side of the SSRAM: synchronous write, read valid in the address cycle.
    always @(posedge clock) if (ramWriteEnableB) mem[ramAddressB] <= ramDataInB;
    assign ramDataOutB = mem[ramAddressB];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [119:0] outs();
        return {busRequest, beginTransaction, readNotWrite, endTransactionOut, dataValidOut,
                addressDataOut, burstSize, ciDone, ciResult,
                ramWriteEnableB, ramAddressB, ramDataInB};
    endfunction

    task automatic ci_access(input logic [2:0] sel, input logic wr, input logic [31:0] val,
                             output logic done, output logic [31:0] res);
        @(negedge clock);
        ciStart = 1'b1;
        ciValueA = {19'd0, sel, wr, 9'd0};
        ciValueB = val;
        @(negedge clock);
        ciStart = 1'b0;
        ciValueA = '0;
        ciValueB = '0;
        done = ciDone;
        res = ciResult;
    endtask

    task automatic ci_write(input logic [2:0] sel, input logic [31:0] val);
        logic d;
        logic [31:0] r;
        ci_access(sel, 1'b1, val, d, r);
    endtask

    task automatic ci_read(input logic [2:0] sel, output logic [31:0] res);
        logic d;
        ci_access(sel, 1'b0, '0, d, res);
    endtask

    // Grants the bus once busRequest is seen and captures the INIT-cycle outputs.
    task automatic bus_grant(output logic [42:0] seen);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (busRequest) found = 1'b1;
            else @(negedge clock);
        end
        seen = '0;
        if (found) begin
            busGrant = 1'b1;
            @(negedge clock);
            busGrant = 1'b0;
            seen = {1'b1, beginTransaction, readNotWrite, burstSize, addressDataOut};
        end
    endtask

    task automatic feed_read(input int n, input logic [31:0] base, input logic with_end);
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
            dataValidIn = 1'b1;
            addressDataIn = base + 32'(i);
            endTransactionIn = with_end && (i == n - 1);
            @(negedge clock);
        end
        dataValidIn = 1'b0;
        addressDataIn = '0;
        endTransactionIn = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        resetN = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", outs());
        end
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL reset_status: got %h want 0", r); end
    endtask

    task automatic test_config();
        logic d;
        logic [31:0] r;
        ci_write(3'd1, 32'h0000_1003);
        ci_access(3'd1, 1'b0, '0, d, r);
        total++;
        if ({d, r} !== {1'b1, 32'h0000_1000}) begin
            bad++; $display("FAIL cfg_bus_start: got done=%b %h want done=1 00001000", d, r);
        end
        @(negedge clock);
        total++;
        if ({ciDone, ciResult} !== 33'd0) begin
            bad++; $display("FAIL ci_done_pulse: got done=%b %h want 0 0", ciDone, ciResult);
        end
        ci_write(3'd3, 32'h0000_07FF);
        ci_read(3'd3, r);
        total++;
        if (r !== 32'h0000_03FF) begin bad++; $display("FAIL cfg_block_size: got %h want 000003ff", r); end
        ci_write(3'd2, 32'h0000_FFFF);
        ci_read(3'd2, r);
        total++;
        if (r !== 32'h0000_01FF) begin bad++; $display("FAIL cfg_mem_start: got %h want 000001ff", r); end
        ci_write(3'd4, 32'h0000_01FF);
        ci_read(3'd4, r);
        total++;
        if (r !== 32'h0000_00FF) begin bad++; $display("FAIL cfg_burst_len: got %h want 000000ff", r); end
        ci_write(3'd6, 32'hDEAD_BEEF);
        ci_read(3'd6, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL cfg_reg6: got %h want 0", r); end
    endtask

    task automatic test_zero_block();
        logic [31:0] r;
        int req_seen;
        ci_write(3'd3, 32'd0);
        ci_write(3'd5, 32'd1);
        req_seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (busRequest) req_seen++;
        end
        ci_read(3'd5, r);
        total++;
        if ({req_seen, r} !== {32'd0, 32'd0}) begin
            bad++; $display("FAIL zero_block: got req=%0d status=%h want 0 0", req_seen, r);
        end
    endtask

    task automatic test_bus_to_mem();
        logic [31:0] r;
        logic [42:0] seen;
        ci_write(3'd3, 32'd8);
        ci_write(3'd4, 32'd3);
        ci_write(3'd2, 32'h10);
        ci_write(3'd1, 32'h2000);
        ci_write(3'd5, 32'd1);
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd1) begin bad++; $display("FAIL b2m_busy: got %h want 1", r); end
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b1, 8'd3, 32'h2000}) begin
            bad++; $display("FAIL b2m_init0: got %h want %h", seen, {1'b1, 1'b1, 1'b1, 8'd3, 32'h2000});
        end
        feed_read(4, 32'hA000_0000, 1'b1);
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b1, 8'd3, 32'h2010}) begin
            bad++; $display("FAIL b2m_init1: got %h want %h", seen, {1'b1, 1'b1, 1'b1, 8'd3, 32'h2010});
        end
        feed_read(4, 32'hA000_0004, 1'b1);
        repeat (3) @(negedge clock);
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL b2m_status_end: got %h want 0", r); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[16 + i] !== 32'hA000_0000 + 32'(i)) begin
                bad++; $display("FAIL b2m_mem[%0d]: got %h want %h", 16 + i, mem[16 + i], 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_mem_to_bus_stall();
        logic [31:0] r;
        logic [42:0] seen;
        logic [8:0] held_addr;
        int k, stalls;
        ci_write(3'd3, 32'd5);
        ci_write(3'd4, 32'd7);
        ci_write(3'd2, 32'h12);
        ci_write(3'd1, 32'h3000);
        ci_write(3'd5, 32'd2);
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b0, 8'd4, 32'h3000}) begin
            bad++; $display("FAIL m2b_init: got %h want %h", seen, {1'b1, 1'b1, 1'b0, 8'd4, 32'h3000});
        end
        k = 0;
        stalls = 0;
        held_addr = '0;
        @(negedge clock);
        for (int c = 0; c < 30 && k < 5; c++) begin
            total++;
            if ({dataValidOut, addressDataOut} !== {1'b1, 32'hA000_0002 + 32'(k)}) begin
                bad++; $display("FAIL m2b_word%0d: got dv=%b %h want dv=1 %h", k, dataValidOut, addressDataOut, 32'hA000_0002 + 32'(k));
            end
            if (k == 2 && stalls < 2) begin
                if (stalls == 0) held_addr = ramAddressB;
                else begin
                    total++;
                    if (ramAddressB !== held_addr) begin
                        bad++; $display("FAIL m2b_stall_addr: got %h want %h", ramAddressB, held_addr);
                    end
                end
                busyIn = 1'b1;
                stalls++;
            end else begin
                busyIn = 1'b0;
                k++;
            end
            @(negedge clock);
        end
        busyIn = 1'b0;
        total++;
        if ({k, endTransactionOut, dataValidOut} !== {32'd5, 1'b1, 1'b0}) begin
            bad++; $display("FAIL m2b_end: got words=%0d eto=%b dv=%b want 5 1 0", k, endTransactionOut, dataValidOut);
        end
        @(negedge clock);
        total++;
        if (endTransactionOut !== 1'b0) begin bad++; $display("FAIL m2b_end_pulse: got %b want 0", endTransactionOut); end
        repeat (2) @(negedge clock);
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL m2b_status_end: got %h want 0", r); end
    endtask

    task automatic test_wrap();
        logic [42:0] seen;
        logic [8:0] exp_addr [4];
        exp_addr = '{9'd510, 9'd511, 9'd0, 9'd1};
        ci_write(3'd3, 32'd4);
        ci_write(3'd4, 32'd7);
        ci_write(3'd2, 32'd510);
        ci_write(3'd1, 32'h100);
        ci_write(3'd5, 32'd1);
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b1, 8'd3, 32'h100}) begin
            bad++; $display("FAIL wrap_init: got %h want %h", seen, {1'b1, 1'b1, 1'b1, 8'd3, 32'h100});
        end
        feed_read(4, 32'hC000_0000, 1'b1);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[exp_addr[i]] !== 32'hC000_0000 + 32'(i)) begin
                bad++; $display("FAIL wrap_mem[%0d]: got %h want %h", exp_addr[i], mem[exp_addr[i]], 32'hC000_0000 + 32'(i));
            end
        end
        total++;
        if (mem[2] !== 32'd0) begin bad++; $display("FAIL wrap_untouched: got %h want 0", mem[2]); end
    endtask

    task automatic test_error_retry();
        logic [31:0] r;
        logic [42:0] seen;
        ci_write(3'd3, 32'd8);
        ci_write(3'd4, 32'd7);
        ci_write(3'd2, 32'h80);
        ci_write(3'd1, 32'h4000);
        ci_write(3'd5, 32'd1);
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b1, 8'd7, 32'h4000}) begin
            bad++; $display("FAIL err_init: got %h want %h", seen, {1'b1, 1'b1, 1'b1, 8'd7, 32'h4000});
        end
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            dataValidIn = 1'b1;
            addressDataIn = 32'hD000_0000 + 32'(i);
            busError = (i == 2);
            @(negedge clock);
        end
        dataValidIn = 1'b0;
        addressDataIn = '0;
        busError = 1'b0;
        total++;
        if (outs() !== '0) begin bad++; $display("FAIL err_outputs: got %h want 0", outs()); end
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd2) begin bad++; $display("FAIL err_status: got %h want 2", r); end
        total++;
        if ({mem[128], mem[129]} !== {32'hD000_0000, 32'hD000_0001}) begin
            bad++; $display("FAIL err_kept_words: got %h %h want d0000000 d0000001", mem[128], mem[129]);
        end
        ci_write(3'd5, 32'd1);
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd1) begin bad++; $display("FAIL retry_status: got %h want 1", r); end
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b1, 8'd7, 32'h4000}) begin
            bad++; $display("FAIL retry_init: got %h want %h", seen, {1'b1, 1'b1, 1'b1, 8'd7, 32'h4000});
        end
        feed_read(8, 32'hE000_0000, 1'b1);
        repeat (3) @(negedge clock);
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL retry_status_end: got %h want 0", r); end
        total++;
        if ({mem[128], mem[135]} !== {32'hE000_0000, 32'hE000_0007}) begin
            bad++; $display("FAIL retry_mem: got %h %h want e0000000 e0000007", mem[128], mem[135]);
        end
    endtask

    task automatic test_ignore_and_reset();
        logic [31:0] r;
        logic [42:0] seen;
        int req_seen;
        ci_write(3'd3, 32'd4);
        ci_write(3'd4, 32'd3);
        ci_write(3'd2, 32'h20);
        ci_write(3'd1, 32'h5000);
        ci_write(3'd5, 32'd1);
        ci_write(3'd3, 32'd12);
        ci_write(3'd5, 32'd1);
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b1, 8'd3, 32'h5000}) begin
            bad++; $display("FAIL ign_init: got %h want %h", seen, {1'b1, 1'b1, 1'b1, 8'd3, 32'h5000});
        end
        feed_read(4, 32'hF000_0000, 1'b1);
        req_seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (busRequest) req_seen++;
        end
        ci_read(3'd5, r);
        total++;
        if ({req_seen, r} !== {32'd0, 32'd0}) begin
            bad++; $display("FAIL ign_second_start: got req=%0d status=%h want 0 0", req_seen, r);
        end
        ci_write(3'd5, 32'd1);
        bus_grant(seen);
        total++;
        if (seen !== {1'b1, 1'b1, 1'b1, 8'd3, 32'h5000}) begin
            bad++; $display("FAIL rst_init: got %h want %h", seen, {1'b1, 1'b1, 1'b1, 8'd3, 32'h5000});
        end
        @(negedge clock);
        dataValidIn = 1'b1;
        addressDataIn = 32'h1234_5678;
        @(negedge clock);
        dataValidIn = 1'b0;
        addressDataIn = '0;
        resetN = 1'b0;
        @(negedge clock);
        total++;
        if (outs() !== '0) begin bad++; $display("FAIL rst_outputs: got %h want 0", outs()); end
        resetN = 1'b1;
        ci_read(3'd5, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL rst_status: got %h want 0", r); end
        ci_read(3'd3, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL rst_block_size: got %h want 0", r); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_zero_block();
        test_bus_to_mem();
        test_mem_to_bus_stall();
        test_wrap();
        test_error_retry();
        test_ignore_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dma_controller.md
# ram_dma_controller

Block-transfer DMA sequencer that owns port B of the CI-accessible dual-port SSRAM and moves word blocks between that SSRAM and the system bus in bursts. The CPU configures it through custom-instruction register accesses; port A of the SSRAM stays with the CPU. One transfer direction is active at a time.

## Interface
- nrOfEntries, 512, SSRAM depth in words; memory address width is $clog2(nrOfEntries).
- clock  in  1  system clock; all logic on rising edge.
- resetN  in  1  synchronous, active-low reset.
- ciStart, ciValueA[31:0], ciValueB[31:0]  in  1/32/32  CI request: ciValueA[12:10] selects the register, ciValueA[9]=1 writes ciValueB.
- ciDone, ciResult[31:0]  out  1/32  CI completion and read data.
- ramAddressB[AW-1:0], ramWriteEnableB, ramDataInB[31:0]  out  port-B address, write enable and write data.
- ramDataOutB[31:0]  in  32  port-B read data; valid within the cycle the address is driven.
- busRequest, beginTransaction, readNotWrite, endTransactionOut, dataValidOut  out  1 each  bus master controls.
- addressDataOut[31:0], burstSize[7:0]  out  bus address/write data; burst length minus 1.
- busGrant, endTransactionIn, dataValidIn, busyIn, busError  in  1 each  bus responses.
- addressDataIn[31:0]  in  32  bus read data.

## Operation
- Registers, selected by ciValueA[12:10]:
  - 001 busStartAddress: 32 bit; bits [1:0] forced to 0.
  - 010 memStartAddress: AW bit.
  - 011 blockSize: 10 bit, in words.
  - 100 burstLen: 8 bit; burst = value+1 words.
  - 101 control: write bit0 starts bus->mem, bit1 starts mem->bus, bit0 has priority if both are set. Read returns {30'b0, error, busy}.
  - 000, 110, 111: reads return 0, writes are ignored.
  - Unused upper bits read as 0.
- Start copies the registers to working counters, clears error and sets busy.
  - Start with blockSize 0 completes immediately; busy stays 0.
  - Start while busy is ignored.
  - Register writes while busy affect only the next transfer.
- FSM states and transitions:
  - IDLE: waits for a start.
  - REQ: busRequest=1 until busGrant.
  - INIT: one cycle. beginTransaction=1, addressDataOut=current bus address, burstSize=min(burstLen+1, remaining)-1, readNotWrite=1 for bus->mem.
  - READ: each cycle with dataValidIn writes addressDataIn to ramAddressB with ramWriteEnableB=1. Memory address increments, remaining decrements. Leaves on endTransactionIn.
  - WRITE: drives ramAddressB; addressDataOut=ramDataOutB with dataValidOut=1.
    - Advances only when busyIn=0.
    - endTransactionOut=1 the cycle after the last word is accepted.
  - DONE: drops busRequest. Bus address advances by 4×words moved. Goes to REQ if remaining>0, otherwise to IDLE and clears busy.
- Memory address wraps modulo nrOfEntries. Bus address wraps at 2^32.
- busError in any non-IDLE state: next state IDLE; error=1, busy=0; bus outputs drop to 0 the next cycle; words already written remain in the SSRAM.
- endTransactionIn arriving before the burst count is reached is treated as an early end. Remaining is reduced only by the words actually moved.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all registers 0, busy=0, error=0. Reset mid-transfer aborts the transfer and drops all bus outputs in the next cycle.
- CI: ciDone=1 for exactly one cycle, the cycle after ciStart. ciResult is valid in that cycle and 0 otherwise. A status read in the same cycle as a start returns the pre-start status.
- Bus outputs are registered. beginTransaction is one cycle, one cycle after busGrant is sampled high.
- READ: a RAM write occurs in the same cycle dataValidIn is sampled.
- WRITE: the first dataValidOut is in the cycle after INIT. While busyIn=1, addressDataOut and ramAddressB hold.
- Minimum 3 overhead cycles per burst (REQ grant, INIT, DONE).

## Test plan
- Config readback: write busStartAddress=0x00001003, then read it → 0x00001000. Write blockSize=0x7FF, then read it → 0x3FF. Reading register 110 → 0.
- Bus->mem: blockSize=8, burstLen=3, memStart=0x10, busStart=0x2000. Expect two bursts: INIT at 0x2000, then INIT at 0x2010, both with burstSize=3. SSRAM[0x10..0x17] holds the 8 read words; status busy then reads 0.
- Mem->bus with stalls: blockSize=5, burstLen=7. Expect one burst with burstSize=4. busyIn held high for 2 cycles on word 2 → dataValidOut and data hold. All 5 words are sent in order, then endTransactionOut is one cycle.
- Wrap: memStart=510 (nrOfEntries=512), blockSize=4, bus->mem. Writes land at 510, 511, 0, 1.
- Error and retry: busError during word 3 of an 8-word burst → status reads 0b10 and all bus outputs are 0. A new start then clears the error and the transfer completes.
- Reset and ignore: start, then issue a second start while busy → it is ignored (one set of INITs only). resetN=0 mid-burst → next cycle all outputs are 0 and status reads 0.
